// File: rtl/register_file_multiport_if.sv
// rtl/register_file_multiport_if.sv - register file access bundle (read, write, lock, clear)
interface register_file_multiport_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 16,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 2
);
    localparam int SEL_WIDTH = $clog2(NUM_REGS);

    logic                                  clear_req;
    logic                                  busy;
    logic [NUM_READ_PORTS*SEL_WIDTH-1:0]   read_sel;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  read_data;
    logic [NUM_READ_PORTS-1:0]             read_locked;
    logic [NUM_WRITE_PORTS-1:0]            write_en;
    logic [NUM_WRITE_PORTS*SEL_WIDTH-1:0]  write_sel;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data;
    logic                                  lock_en;
    logic [SEL_WIDTH-1:0]                  lock_sel;

    modport master (
        output clear_req, read_sel, write_en, write_sel, write_data, lock_en, lock_sel,
        input  busy, read_data, read_locked
    );

    modport slave (
        input  clear_req, read_sel, write_en, write_sel, write_data, lock_en, lock_sel,
        output busy, read_data, read_locked
    );
endinterface

// File: rtl/register_file_multiport.sv
// rtl/register_file_multiport.sv - multiport register file with clear sequencer and lock scoreboard
module register_file_multiport #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 16,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int ZERO_REG        = 1,
    parameter int BYPASS          = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    register_file_multiport_if.slave   bus
);
    localparam int SEL_WIDTH = $clog2(NUM_REGS);
    localparam bit ZR        = (ZERO_REG != 0);
    localparam bit BP        = (BYPASS != 0);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);

    typedef enum logic {IDLE = 1'b0, CLEARING = 1'b1} state_t;

    state_t                      state, state_next;
    logic [SEL_WIDTH-1:0]        clear_idx;
    logic [DATA_WIDTH-1:0]       regs [NUM_REGS];
    logic [NUM_REGS-1:0]         lock;
    logic [NUM_WRITE_PORTS-1:0]  we_eff;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_all;
    logic [NUM_READ_PORTS-1:0]   rl_all;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEARING;
            clear_idx <= '0;
        end else begin
            state <= state_next;
            if (state == CLEARING)
                clear_idx <= clear_idx + 1'b1;
            else
                clear_idx <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (bus.clear_req) state_next = CLEARING;
            CLEARING: if (clear_idx == LAST_IDX) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CLEARING);
    end

    // A write commits only in IDLE and never to the hardwired zero register.
    always_comb begin
        we_eff = '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            we_eff[p] = (state == IDLE) && bus.write_en[p] &&
                        !(ZR && (bus.write_sel[p*SEL_WIDTH +: SEL_WIDTH] == '0));
        end
    end

    // Storage is not reset; the clear sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEARING) begin
                regs[clear_idx] <= '0;
            end else begin
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    if (we_eff[p])
                        regs[bus.write_sel[p*SEL_WIDTH +: SEL_WIDTH]] <=
                            bus.write_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Later assignments win: a new producer's lock overrides a retiring write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock <= '0;
        end else if (state == IDLE) begin
            if (bus.clear_req) begin
                lock <= '0;
            end else begin
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    if (we_eff[p])
                        lock[bus.write_sel[p*SEL_WIDTH +: SEL_WIDTH]] <= 1'b0;
                end
                if (bus.lock_en && !(ZR && (bus.lock_sel == '0)))
                    lock[bus.lock_sel] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_all = '0;
        rl_all = '0;
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            logic [SEL_WIDTH-1:0]  rs;
            logic [DATA_WIDTH-1:0] d;
            logic                  l;
            rs = bus.read_sel[i*SEL_WIDTH +: SEL_WIDTH];
            d  = regs[rs];
            l  = lock[rs];
            if (BP) begin
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    if (we_eff[p] && (bus.write_sel[p*SEL_WIDTH +: SEL_WIDTH] == rs)) begin
                        d = bus.write_data[p*DATA_WIDTH +: DATA_WIDTH];
                        l = 1'b0;
                    end
                end
            end
            if (ZR && (rs == '0)) begin
                d = '0;
                l = 1'b0;
            end
            if (state == CLEARING) begin
                d = '0;
                l = 1'b0;
            end
            rd_all[i*DATA_WIDTH +: DATA_WIDTH] = d;
            rl_all[i] = l;
        end
    end

    assign bus.read_data   = rd_all;
    assign bus.read_locked = rl_all;
endmodule
